// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multi-cycle RV32I-subset sequencer: state codes, opcodes,
// ALU operation codes and datapath select encodings.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StAluWb    = 4'd7,
    StExecI    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10
  } state_e;

  // Which ALU decode rule applies in the current state
  typedef enum logic [1:0] {
    AluClsAdd,
    AluClsSub,
    AluClsR,
    AluClsI
  } alu_cls_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU operation decode: maps the state's ALU class plus funct3/funct7b5 to an ALU code.
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  alu_cls_e    alu_cls,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  output logic [3:0]  alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_cls)
      AluClsSub: alu_control = ALU_SUB;
      AluClsR: begin
        case ({funct7b5, funct3})
          4'b1000: alu_control = ALU_SUB;
          4'b0111: alu_control = ALU_AND;
          4'b0110: alu_control = ALU_OR;
          default: alu_control = ALU_ADD;
        endcase
      end
      AluClsI: begin
        case (funct3)
          3'b111:  alu_control = ALU_AND;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing FSM driving the registered RV32I-subset datapath.
// Optional jal support is enabled with the MULTICYCLE_CTRL_JAL_EN macro.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 4,
  parameter int unsigned STATE_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  adr_src,
  output logic                  ir_write,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            imm_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  instr_done,
  output logic                  illegal_op,
  output logic [STATE_W-1:0]    dbg_state
);

  state_e     state_q, state_d;
  alu_cls_e   alu_cls;
  logic [3:0] alu_dec;

  alu_decoder u_alu_decoder (
    .alu_cls     (alu_cls),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (alu_dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StFetch;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_B;
    imm_src    = IMM_I;
    alu_cls    = AluClsAdd;
    instr_done = 1'b0;
    illegal_op = 1'b0;

    case (state_q)
      StFetch: begin
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        // Precompute the branch/jump target into ALUOut
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
`ifdef MULTICYCLE_CTRL_JAL_EN
        imm_src   = (op == OP_JAL) ? IMM_J : IMM_B;
`else
        imm_src   = IMM_B;
`endif
        case (op)
          OP_LOAD, OP_STORE: state_d = StMemAdr;
          OP_R:              state_d = StExecR;
          OP_I:              state_d = StExecI;
          OP_BRANCH:         state_d = StBeq;
`ifdef MULTICYCLE_CTRL_JAL_EN
          OP_JAL:            state_d = StJal;
`endif
          default: begin
            state_d    = StFetch;
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
        state_d   = (op == OP_STORE) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = StFetch;
        end
      end
      StExecR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_B;
        alu_cls   = AluClsR;
        state_d   = StAluWb;
      end
      StExecI: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_I;
        alu_cls   = AluClsI;
        state_d   = StAluWb;
      end
      StAluWb: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StBeq: begin
        alu_src_a  = SRCA_A;
        alu_src_b  = SRCB_B;
        alu_cls    = AluClsSub;
        result_src = RES_ALUOUT;
        pc_write   = zero;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
`ifdef MULTICYCLE_CTRL_JAL_EN
      StJal: begin
        // PC takes the target from ALUOut while ALU forms the link OldPC+4
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        state_d    = StAluWb;
      end
`endif
      default: state_d = StFetch;
    endcase

    if (rst) begin
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      imm_src    = 2'b00;
      alu_cls    = AluClsAdd;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign alu_control = ALU_CTRL_W'(alu_dec);
  assign dbg_state   = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed spec scenarios plus randomized
// instruction streams compared against a per-instruction expected-trace model.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, ir_write, mem_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [3:0] alu_control;
  logic       instr_done, illegal_op;
  logic [3:0] dbg_state;

  int errors = 0;
  int checks = 0;

`ifdef MULTICYCLE_CTRL_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4;
  localparam int S_MEMWRITE = 5, S_EXECR = 6, S_ALUWB = 7, S_EXECI = 8, S_BEQ = 9;
  localparam int S_JAL = 10;

  multicycle_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .ir_write    (ir_write),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .alu_control (alu_control),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  // strb = {pc_write, ir_write, mem_write, reg_write, adr_src, instr_done, illegal_op}
  typedef struct {
    int         st;
    logic       mr;
    logic       z;
    logic [6:0] strb;
    bit         chk_alu;
    logic [3:0] alu;
    bit         chk_imm;
    logic [1:0] imm;
    bit         chk_res;
    logic [1:0] res;
  } cyc_t;

  cyc_t exp_q[$];

  function automatic cyc_t mk(input int st, input logic [6:0] strb);
    cyc_t c;
    c.st = st; c.strb = strb;
    c.mr = 1'($urandom); c.z = 1'($urandom);
    c.chk_alu = 0; c.alu = 0; c.chk_imm = 0; c.imm = 0; c.chk_res = 0; c.res = 0;
    return c;
  endfunction

  function automatic logic [3:0] alu_ref_r(input logic f7, input logic [2:0] f3);
    if (f3 == 3'd0 && f7)  return 4'd1;   // sub
    if (f3 == 3'd7 && !f7) return 4'd2;   // and
    if (f3 == 3'd6 && !f7) return 4'd3;   // or
    return 4'd0;
  endfunction

  function automatic logic [3:0] alu_ref_i(input logic [2:0] f3);
    if (f3 == 3'd7) return 4'd2;
    if (f3 == 3'd6) return 4'd3;
    return 4'd0;
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    return o == 7'b0110011 || o == 7'b0010011 || o == 7'b0000011 || o == 7'b0100011 ||
           o == 7'b1100011 || (JAL_EN && o == 7'b1101111);
  endfunction

  // Expected cycle-by-cycle trace of one instruction, from the instruction's semantics
  task automatic build(input logic [31:0] ins, input int fw, input int mw, input logic z);
    logic [6:0] o;
    cyc_t c;
    o = ins[6:0];
    exp_q.delete();
    for (int k = 0; k <= fw; k++) begin
      logic rdy;
      rdy = (k == fw);
      c = mk(S_FETCH, {rdy, rdy, 5'b0});
      c.mr = rdy; c.chk_res = 1; c.res = 2'b10; c.chk_alu = 1; c.alu = 4'd0;
      exp_q.push_back(c);
    end
    c = mk(S_DECODE, is_legal(o) ? 7'b0 : 7'b0000011);
    c.chk_imm = 1; c.imm = (JAL_EN && o == 7'b1101111) ? 2'b11 : 2'b10;
    c.chk_alu = 1; c.alu = 4'd0;
    exp_q.push_back(c);
    if (!is_legal(o)) return;
    case (o)
      7'b0000011, 7'b0100011: begin
        c = mk(S_MEMADR, 7'b0); c.chk_imm = 1; c.imm = (o == 7'b0100011) ? 2'b01 : 2'b00;
        c.chk_alu = 1; c.alu = 4'd0;
        exp_q.push_back(c);
        for (int k = 0; k <= mw; k++) begin
          logic rdy;
          rdy = (k == mw);
          if (o == 7'b0000011) begin
            c = mk(S_MEMREAD, 7'b0000100); c.chk_res = 1; c.res = 2'b00;
          end else begin
            c = mk(S_MEMWRITE, {2'b00, 1'b1, 1'b0, 1'b1, rdy, 1'b0});
          end
          c.mr = rdy;
          exp_q.push_back(c);
        end
        if (o == 7'b0000011) begin
          c = mk(S_MEMWB, 7'b0001010); c.chk_res = 1; c.res = 2'b01;
          exp_q.push_back(c);
        end
      end
      7'b0110011, 7'b0010011: begin
        if (o == 7'b0110011) begin
          c = mk(S_EXECR, 7'b0); c.alu = alu_ref_r(ins[30], ins[14:12]);
        end else begin
          c = mk(S_EXECI, 7'b0); c.alu = alu_ref_i(ins[14:12]);
          c.chk_imm = 1; c.imm = 2'b00;
        end
        c.chk_alu = 1;
        exp_q.push_back(c);
        c = mk(S_ALUWB, 7'b0001010); c.chk_res = 1; c.res = 2'b00;
        exp_q.push_back(c);
      end
      7'b1100011: begin
        c = mk(S_BEQ, {z, 4'b0000, 1'b1, 1'b0}); c.z = z;
        c.chk_alu = 1; c.alu = 4'd1; c.chk_res = 1; c.res = 2'b00;
        exp_q.push_back(c);
      end
      default: begin
        c = mk(S_JAL, 7'b1000000); c.chk_alu = 1; c.alu = 4'd0; c.chk_res = 1; c.res = 2'b00;
        exp_q.push_back(c);
        c = mk(S_ALUWB, 7'b0001010); c.chk_res = 1; c.res = 2'b00;
        exp_q.push_back(c);
      end
    endcase
  endtask

  // Assumes DUT in FETCH, called #1 after a rising edge
  task automatic run_instr(input string name, input logic [31:0] ins, input int fw,
                           input int mw, input logic z);
    logic [6:0] act;
    build(ins, fw, mw, z);
    op = ins[6:0]; funct3 = ins[14:12]; funct7b5 = ins[30];
    for (int i = 0; i < exp_q.size(); i++) begin
      mem_ready = exp_q[i].mr;
      zero      = exp_q[i].z;
      @(negedge clk);
      act = {pc_write, ir_write, mem_write, reg_write, adr_src, instr_done, illegal_op};
      checks++;
      if (dbg_state !== 4'(exp_q[i].st)) begin
        errors++;
        $display("FAIL %s cyc%0d state: got %0d want %0d", name, i, dbg_state, exp_q[i].st);
      end
      checks++;
      if (act !== exp_q[i].strb) begin
        errors++;
        $display("FAIL %s cyc%0d strobes(pc,ir,mw,rw,adr,done,ill): got %b want %b",
                 name, i, act, exp_q[i].strb);
      end
      if (exp_q[i].chk_alu) begin
        checks++;
        if (alu_control !== exp_q[i].alu) begin
          errors++;
          $display("FAIL %s cyc%0d alu_control: got %b want %b", name, i, alu_control,
                   exp_q[i].alu);
        end
      end
      if (exp_q[i].chk_imm) begin
        checks++;
        if (imm_src !== exp_q[i].imm) begin
          errors++;
          $display("FAIL %s cyc%0d imm_src: got %b want %b", name, i, imm_src, exp_q[i].imm);
        end
      end
      if (exp_q[i].chk_res) begin
        checks++;
        if (result_src !== exp_q[i].res) begin
          errors++;
          $display("FAIL %s cyc%0d result_src: got %b want %b", name, i, result_src,
                   exp_q[i].res);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [18:0] all_outs();
    return {pc_write, adr_src, ir_write, mem_write, reg_write, result_src, alu_src_a,
            alu_src_b, imm_src, alu_control, instr_done, illegal_op};
  endfunction

  task automatic test_reset();
    rst = 1'b1; op = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (dbg_state !== 4'd0 || all_outs() !== 19'd0) begin
        errors++;
        $display("FAIL reset hold: got state %0d outs %h want 0 0", dbg_state, all_outs());
      end
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state !== 4'd0 || {ir_write, pc_write} !== 2'b11) begin
      errors++;
      $display("FAIL reset release: got state %0d ir/pc %b want 0 11", dbg_state,
               {ir_write, pc_write});
    end
    mem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_ops();
    run_instr("add", 32'h002081B3, 0, 0, 1'b0);
    run_instr("sub", 32'h402081B3, 0, 0, 1'b0);
    run_instr("ori", 32'h0050E093, 1, 0, 1'b0);
  endtask

  task automatic test_load_store();
    run_instr("lw_wait2", 32'h00402283, 0, 2, 1'b0);
    run_instr("sw_wait1", 32'h00502423, 0, 1, 1'b0);
  endtask

  task automatic test_branch();
    run_instr("beq_taken", 32'h00208463, 0, 0, 1'b1);
    run_instr("beq_not", 32'h00208463, 0, 0, 1'b0);
  endtask

  task automatic test_jal_or_illegal();
    run_instr("jal", 32'h0080006F, 0, 0, 1'b0);
    run_instr("illegal", 32'h0000007F, 0, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state !== 4'd3) begin
      errors++;
      $display("FAIL midrst reach MEMREAD: got %0d want 3", dbg_state);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (dbg_state !== 4'd0 || all_outs() !== 19'd0) begin
      errors++;
      $display("FAIL midrst async: got state %0d outs %h want 0 0", dbg_state, all_outs());
    end
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (dbg_state !== 4'd0 || {mem_write, reg_write, pc_write, ir_write} !== 4'b0) begin
      errors++;
      $display("FAIL midrst held: got state %0d en %b want 0 0000", dbg_state,
               {mem_write, reg_write, pc_write, ir_write});
    end
    #1 rst = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [6:0]  o;
    for (int n = 0; n < 60; n++) begin
      ins = $urandom;
      case ($urandom_range(0, 6))
        0: begin o = 7'b0110011; ins[31] = 1'b0; ins[29:25] = 5'd0; end
        1: o = 7'b0010011;
        2: begin o = 7'b0000011; ins[14:12] = 3'b010; end
        3: begin o = 7'b0100011; ins[14:12] = 3'b010; end
        4: begin o = 7'b1100011; ins[14:12] = 3'b000; end
        5: o = 7'b1101111;
        default: begin
          o = 7'($urandom);
          while (is_legal(o)) o = 7'($urandom);
        end
      endcase
      ins[6:0] = o;
      run_instr($sformatf("rand%0d_op%b", n, o), ins, $urandom_range(0, 2),
                $urandom_range(0, 3), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_load_store();
    test_branch();
    test_jal_or_illegal();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
